bypass_hazard_ctrl: RTL
=======================

Name: bypass_hazard_ctrl

Overview:
- Hazard and forwarding scheduler for the ID stage of the 5-stage in-order pipeline.
- Keeps a shadow copy of the EXE/MEM/WB destination-register state, compares it against the ID instruction's sources, and decides for each source operand:
  - which bypass source feeds it, or
  - whether ID must stall.
- Inserts bubbles on stall, clears shadow entries on branch flush, and counts stall cycles for performance monitoring.

Parameters:
- RF_AW, 5, register-address width.
- STALL_CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- pipe_adv  in  1  all stages advance at this posedge; 0 = whole pipeline holds
- flush  in  1  branch mispredict resolved in EXE; kills the ID and EXE instructions
- id_valid  in  1  ID holds a valid instruction
- id_rs1_addr  in  RF_AW  source 1 address
- id_rs1_used  in  1  source 1 is read
- id_rs2_addr  in  RF_AW  source 2 address
- id_rs2_used  in  1  source 2 is read
- id_rd_addr  in  RF_AW  destination address
- id_rd_we  in  1  instruction writes the register file
- id_rdy_stage  in  2  stage where the result becomes forwardable: 0=EXE (ALU), 1=MEM (load), 2=WB (e.g. CSR/mul); 3 is illegal and is treated as 2
- id_issue  out  1  ID instruction enters EXE at the next pipe_adv
- id_stall  out  1  ID must hold
- rs1_sel  out  2  source 1 bypass select: 0=RF, 1=EXE, 2=MEM, 3=WB
- rs2_sel  out  2  source 2 bypass select, same encoding
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with id_stall=1 and pipe_adv=1

Behaviour:
- Reset (asynchronous, resetn=0):
  - Shadow slots EXE/MEM/WB all invalid; stall_cycles=0.
  - Outputs then read id_issue=id_valid, id_stall=0, rs1_sel=rs2_sel=0.
- Shadow slot contents: each of EXE (index 0), MEM (1) and WB (2) holds {v, rd, we, rdy}.
- Match rule for a source s (rs1 or rs2) against slot k:
  - match when s_used=1, s_addr!=0, slot.v=1, slot.we=1 and slot.rd==s_addr.
  - Address 0 never matches: sel=0, no stall.
- Source resolution is combinational, checking the youngest slot first: EXE, then MEM, then WB.
  - The first matching slot k decides the source.
  - If k >= slot.rdy (result available), sel=k+1.
  - Otherwise the source is not ready and sel=0.
  - No match: sel=0.
  - Older slots are never used when a younger slot matches, even if the younger one is not ready.
- Stall and issue:
  - id_stall = id_valid & ~flush & (rs1 not ready | rs2 not ready).
  - id_issue = id_valid & ~flush & ~id_stall.
  - Both are purely combinational, with zero-cycle latency.
- Sequential update at posedge clk when pipe_adv=1:
  - WB <= MEM; MEM <= EXE.
  - EXE <= id_issue ? {1, id_rd_addr, id_rd_we, id_rdy_stage} : bubble (v=0).
  - Stalled or flushed ID therefore inserts a bubble.
- When pipe_adv=0: all slots hold, except that flush=1 clears EXE.v at the edge.
- When flush=1 and pipe_adv=1: MEM receives a bubble rather than the killed EXE entry; WB <= MEM as normal; EXE <= bubble.
- stall_cycles:
  - increments at posedge when id_stall & pipe_adv;
  - saturates at all-ones with no wrap.
- Reset mid-operation: all shadow state is lost immediately and outputs drop to reset values asynchronously. Re-issue after reset is the pipeline's responsibility.
- Load-use case: a load (rdy=1) in EXE matched by ID stalls exactly one advancing cycle. The load then sits in MEM, so sel=2 and the instruction issues.
- A WB-ready producer (rdy=2) stalls two advancing cycles when in EXE and one when in MEM.

Test Plan:
- Reset then id_valid=1, rs1=5 used, no producers -> id_issue=1, id_stall=0, rs1_sel=0, stall_cycles=0.
- ALU `add r3` issued (rdy=0), next cycle ID reads r3 as rs1 and rs2 -> rs1_sel=rs2_sel=1, no stall. After 2 more advances with no further writers -> sel=3, then 0.
- Load `r4` (rdy=1) issued, then ID reads r4 -> id_stall=1 for one advance, EXE gets a bubble, stall_cycles=1. Next cycle rs1_sel=2, id_issue=1.
- `add r6` followed by `ld r6` (rdy=1), then ID reads r6 -> youngest (the load in EXE) is not ready -> stall; no forward from the older add. After one advance sel=2.
- Destination r0 with rs1=0, and a producer writing r0 -> sel=0, never stalls.
- flush=1 with pipe_adv=1 while EXE holds `r7` and ID reads r7 -> id_issue=0; next cycle MEM.v=0 and EXE.v=0; a later reader of r7 sees sel=0.

Source files
------------

// File: rtl/bypass_hazard_ctrl.sv
// bypass_hazard_ctrl
// ID-stage hazard and forwarding scheduler for a 5-stage in-order pipeline.
// It keeps a shadow copy of the destination-register state of the EXE, MEM and
// WB stages (slot 0 = EXE, 1 = MEM, 2 = WB). For each ID source operand it picks
// a bypass source, or it asks ID to stall.
//
// Handshake: the ID instruction is accepted into EXE exactly at a posedge where
// pipe_adv=1 and id_issue=1. id_issue behaves as "valid and not blocked". It is
// combinational from the ID inputs and the shadow state. pipe_adv behaves as a
// global ready: when it is low, every stage holds.
module bypass_hazard_ctrl #(
    parameter int RF_AW       = 5,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   pipe_adv,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [RF_AW-1:0]       id_rs1_addr,
    input  logic                   id_rs1_used,
    input  logic [RF_AW-1:0]       id_rs2_addr,
    input  logic                   id_rs2_used,
    input  logic [RF_AW-1:0]       id_rd_addr,
    input  logic                   id_rd_we,
    input  logic [1:0]             id_rdy_stage,
    output logic                   id_issue,
    output logic                   id_stall,
    output logic [1:0]             rs1_sel,
    output logic [1:0]             rs2_sel,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int NSLOT = 3;

    // Shadow slots. index 0 = EXE, 1 = MEM, 2 = WB.
    logic [NSLOT-1:0] slot_v;
    logic [NSLOT-1:0] slot_we;
    logic [RF_AW-1:0] slot_rd  [NSLOT];
    logic [1:0]       slot_rdy [NSLOT];

    // Per-slot match flags for each source, and the per-slot result-available flags.
    logic [NSLOT-1:0] rs1_hit;
    logic [NSLOT-1:0] rs2_hit;
    logic [NSLOT-1:0] slot_ready;

    logic rs1_wait;
    logic rs2_wait;

    // An illegal ready stage (3) is stored as WB (2). This keeps the WB slot always ready.
    logic [1:0] new_rdy;
    assign new_rdy = (id_rdy_stage == 2'd3) ? 2'd2 : id_rdy_stage;

    // Source address 0 is hard-wired zero, so it never matches a producer.
    for (genvar k = 0; k < NSLOT; k++) begin : g_match
        assign rs1_hit[k] = id_rs1_used && (id_rs1_addr != '0) && slot_v[k] &&
                            slot_we[k] && (slot_rd[k] == id_rs1_addr);
        assign rs2_hit[k] = id_rs2_used && (id_rs2_addr != '0) && slot_v[k] &&
                            slot_we[k] && (slot_rd[k] == id_rs2_addr);
        assign slot_ready[k] = (2'(k) >= slot_rdy[k]);
    end

    // Source 1 resolution. The youngest matching slot wins, even when it is not ready.
    always_comb begin
        rs1_sel  = 2'd0;
        rs1_wait = 1'b0;
        if (rs1_hit[0]) begin
            if (slot_ready[0]) rs1_sel = 2'd1;
            else               rs1_wait = 1'b1;
        end else if (rs1_hit[1]) begin
            if (slot_ready[1]) rs1_sel = 2'd2;
            else               rs1_wait = 1'b1;
        end else if (rs1_hit[2]) begin
            if (slot_ready[2]) rs1_sel = 2'd3;
            else               rs1_wait = 1'b1;
        end
    end

    // Source 2 resolution. It uses the same youngest-first priority as source 1.
    always_comb begin
        rs2_sel  = 2'd0;
        rs2_wait = 1'b0;
        if (rs2_hit[0]) begin
            if (slot_ready[0]) rs2_sel = 2'd1;
            else               rs2_wait = 1'b1;
        end else if (rs2_hit[1]) begin
            if (slot_ready[1]) rs2_sel = 2'd2;
            else               rs2_wait = 1'b1;
        end else if (rs2_hit[2]) begin
            if (slot_ready[2]) rs2_sel = 2'd3;
            else               rs2_wait = 1'b1;
        end
    end

    // Stall and issue decision. A flushed ID neither stalls nor issues.
    always_comb begin
        id_stall = id_valid && !flush && (rs1_wait || rs2_wait);
        id_issue = id_valid && !flush && !id_stall;
    end

    // EXE slot: it captures the issuing instruction or a bubble. A flush kills it even while the pipe holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_v[0]   <= 1'b0;
            slot_we[0]  <= 1'b0;
            slot_rd[0]  <= '0;
            slot_rdy[0] <= 2'd0;
        end else if (pipe_adv) begin
            slot_v[0]   <= id_issue;
            slot_we[0]  <= id_rd_we;
            slot_rd[0]  <= id_rd_addr;
            slot_rdy[0] <= new_rdy;
        end else if (flush) begin
            slot_v[0]   <= 1'b0;
        end
    end

    // MEM slot: it takes the EXE entry on advance. A flushed EXE entry becomes a bubble.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_v[1]   <= 1'b0;
            slot_we[1]  <= 1'b0;
            slot_rd[1]  <= '0;
            slot_rdy[1] <= 2'd0;
        end else if (pipe_adv) begin
            slot_v[1]   <= slot_v[0] && !flush;
            slot_we[1]  <= slot_we[0];
            slot_rd[1]  <= slot_rd[0];
            slot_rdy[1] <= slot_rdy[0];
        end
    end

    // WB slot: it takes the MEM entry on advance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_v[2]   <= 1'b0;
            slot_we[2]  <= 1'b0;
            slot_rd[2]  <= '0;
            slot_rdy[2] <= 2'd0;
        end else if (pipe_adv) begin
            slot_v[2]   <= slot_v[1];
            slot_we[2]  <= slot_we[1];
            slot_rd[2]  <= slot_rd[1];
            slot_rdy[2] <= slot_rdy[1];
        end
    end

    // Saturating count of stall cycles that actually advance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if (id_stall && pipe_adv && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
